// File: rtl/cpu_fetch_pkg.sv
// Shared constants, the instruction slot record and an alignment helper for the fetch stage.
package cpu_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES       = 32'd4;
    localparam logic [31:0] PC_R15_OFFSET    = 32'd8;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
    } fetch_slot_t;

    // Branch targets are forced onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_req_port.sv
// Instruction-memory handshake: owns the fetch PC, the single outstanding request,
// wrong-path discard and the sticky timeout flag. Reports accepted words upstream.
module fetch_req_port
    import cpu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = RESET_PC_DEFAULT,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_issue_ok,
    input  logic        i_redirect,
    input  logic [31:0] i_target,
    input  logic        i_imem_ack,
    output logic        o_accept,
    output logic [31:0] o_accept_addr,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    output logic        o_fetch_err
);

    localparam int             CNT_W    = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FETCH_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

    // The request line doubles as the outstanding flag: it is held exactly until the ack.
    logic             r_req;
    logic [31:0]      r_addr;
    logic [31:0]      r_fpc;
    logic             r_discard;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    // A word is kept only if it is not a known wrong-path fetch and no redirect is retiring now.
    assign o_accept      = r_req & i_imem_ack & ~r_discard & ~i_redirect;
    assign o_accept_addr = r_addr;
    assign o_imem_req    = r_req;
    assign o_imem_addr   = r_addr;
    assign o_fetch_err   = r_err;

    // Request issue/complete, discard tracking, timeout counting and fetch-PC update.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req     <= 1'b0;
            r_addr    <= RESET_PC;
            r_fpc     <= RESET_PC;
            r_discard <= 1'b0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
        end else begin
            if (r_req) begin
                if (i_imem_ack) begin
                    r_req     <= 1'b0;
                    r_cnt     <= '0;
                    r_discard <= 1'b0;
                    if (o_accept) begin
                        r_fpc <= r_fpc + WORD_BYTES;
                    end
                end else begin
                    if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (r_cnt == CNT_LAST) begin
                        r_err <= 1'b1;
                    end
                    if (i_redirect) begin
                        r_discard <= 1'b1;
                    end
                end
            end else if (i_issue_ok) begin
                // A redirect retiring this cycle sends the very next request to its target.
                r_req  <= 1'b1;
                r_addr <= i_redirect ? i_target : r_fpc;
            end
            if (i_redirect) begin
                r_fpc <= i_target;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage top: current and prefetch instruction slots in front of decode,
// fed by the memory handshake port.
module fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = RESET_PC_DEFAULT,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] PC,
    output logic [31:0] PCPlus8,
    input  logic        PCSrc,
    input  logic [31:0] Result,
    output logic        FetchErr
);

    fetch_slot_t r_cur;
    fetch_slot_t r_pre;

    logic        w_retire;
    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_issue_ok;
    logic        w_accept;
    logic [31:0] w_accept_addr;

    assign w_retire   = r_cur.valid & InstrReady;
    assign w_redirect = w_retire & PCSrc;
    assign w_target   = word_align(Result);
    // Only fetch when the returning word is guaranteed a slot.
    assign w_issue_ok = ~(r_cur.valid & r_pre.valid & ~w_retire);

    fetch_req_port #(
        .RESET_PC      (RESET_PC),
        .FETCH_TIMEOUT (FETCH_TIMEOUT)
    ) u_req_port (
        .clk           (clk),
        .reset         (reset),
        .i_issue_ok    (w_issue_ok),
        .i_redirect    (w_redirect),
        .i_target      (w_target),
        .i_imem_ack    (imem_ack),
        .o_accept      (w_accept),
        .o_accept_addr (w_accept_addr),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .o_fetch_err   (FetchErr)
    );

    assign Instr      = r_cur.instr;
    assign InstrValid = r_cur.valid;
    assign PC         = r_cur.pc;
    assign PCPlus8    = r_cur.pc + PC_R15_OFFSET;

    // Slot management: redirect flushes both slots, otherwise retire advances and acks fill.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur <= '{instr: 32'h0, pc: RESET_PC, valid: 1'b0};
            r_pre <= '{instr: 32'h0, pc: RESET_PC, valid: 1'b0};
        end else if (w_redirect) begin
            r_cur.valid <= 1'b0;
            r_cur.pc    <= w_target;
            r_pre.valid <= 1'b0;
        end else begin
            if (w_retire) begin
                if (r_pre.valid) begin
                    // The prefetched word always sits at PC+4.
                    r_cur.instr <= r_pre.instr;
                    r_cur.pc    <= r_pre.pc;
                    r_pre.valid <= 1'b0;
                end else begin
                    r_cur.valid <= 1'b0;
                end
            end
            if (w_accept) begin
                if (~r_cur.valid | (w_retire & ~r_pre.valid)) begin
                    r_cur.instr <= imem_rdata;
                    r_cur.pc    <= w_accept_addr;
                    r_cur.valid <= 1'b1;
                end else begin
                    r_pre.instr <= imem_rdata;
                    r_pre.pc    <= w_accept_addr;
                    r_pre.valid <= 1'b1;
                end
            end
        end
    end

endmodule
